// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//
// Purpose:
//   Shares the single external DRAM port between two masters. Master 0 is the
//   core's memory controller and master 1 is a debug/DMA requester. One access
//   is in flight at a time. Ties are broken round-robin. Each access issues a
//   one-cycle read or write command, then waits for dram_ack. A watchdog
//   completes the access with an error flag if the DRAM never answers, so the
//   requesting master cannot hang.
//
// Ports:
//   clk                  clock
//   reset_n              asynchronous active-low reset
//   sync_reset           synchronous reset, same effect as reset_n
//   m_req[1:0]           per-master request level, held until that master's ack
//   m_we[1:0]            per-master 1=write, 0=read
//   m_addr               packed word addresses, master 0 in the low slice
//   m_byte_enable        packed byte enables, master 0 in the low slice
//   m_wdata              packed write data, master 0 in the low slice
//   m_ack[1:0]           one-cycle completion pulse to the served master
//   m_err[1:0]           one-cycle timeout flag, coincident with m_ack
//   m_rdata              read data, valid while any m_ack bit is high
//   dram_mem_addr        DRAM word address, held for the whole access
//   dram_mem_read_en     one-cycle read command
//   dram_mem_write_en    one-cycle write command
//   dram_mem_byte_enable DRAM byte enables, held for the whole access
//   dram_mem_write_data  DRAM write data, held for the whole access
//   dram_ack             DRAM completion pulse
//   dram_mem_read_data   DRAM read data, valid with dram_ack
//   busy                 high whenever an access is in progress
// ---------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int ADDR_BITS      = 24,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sync_reset,
  input  logic [1:0]                 m_req,
  input  logic [1:0]                 m_we,
  input  logic [2*ADDR_BITS-1:0]     m_addr,
  input  logic [2*DATA_BITS/8-1:0]   m_byte_enable,
  input  logic [2*DATA_BITS-1:0]     m_wdata,
  output logic [1:0]                 m_ack,
  output logic [1:0]                 m_err,
  output logic [DATA_BITS-1:0]       m_rdata,
  output logic [ADDR_BITS-1:0]       dram_mem_addr,
  output logic                       dram_mem_read_en,
  output logic                       dram_mem_write_en,
  output logic [DATA_BITS/8-1:0]     dram_mem_byte_enable,
  output logic [DATA_BITS-1:0]       dram_mem_write_data,
  input  logic                       dram_ack,
  input  logic [DATA_BITS-1:0]       dram_mem_read_data,
  output logic                       busy
);

  localparam int BE_BITS  = DATA_BITS / 8;
  localparam int CNT_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Per-master views of the packed request buses
  // -------------------------------------------------------------------------
  logic [ADDR_BITS-1:0] addr_arr  [2];
  logic [BE_BITS-1:0]   be_arr    [2];
  logic [DATA_BITS-1:0] wdata_arr [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_addr[gi*ADDR_BITS +: ADDR_BITS];
    assign be_arr[gi]    = m_byte_enable[gi*BE_BITS +: BE_BITS];
    assign wdata_arr[gi] = m_wdata[gi*DATA_BITS +: DATA_BITS];
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t               state_q, state_d;
  // grant_q doubles as last_grant: it names the master currently being served
  // and, once idle, the master that won most recently.
  logic                 grant_q, grant_d;
  // Set for exactly the first idle cycle after an access: the master just
  // served (grant_q) is ignored so it has time to drop its request.
  logic                 mask_q, mask_d;
  logic                 we_q, we_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  logic [1:0]           m_ack_q, m_ack_d;
  logic [1:0]           m_err_q, m_err_d;
  logic [DATA_BITS-1:0] m_rdata_q, m_rdata_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [BE_BITS-1:0]   be_q, be_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 busy_q, busy_d;

  logic [1:0]           req_eff;
  logic                 winner;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    mask_d    = 1'b0;
    we_d      = we_q;
    cnt_d     = cnt_q;
    m_ack_d   = 2'b00;
    m_err_d   = 2'b00;
    m_rdata_d = m_rdata_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    be_d      = be_q;
    wdata_d   = wdata_q;

    req_eff = m_req;
    if (mask_q) begin
      req_eff[grant_q] = 1'b0;
    end

    // Sole requester wins; on a tie the master that did not win last time.
    winner = (req_eff == 2'b11) ? ~grant_q : req_eff[1];

    unique case (state_q)
      IDLE: begin
        if (|req_eff) begin
          grant_d = winner;
          we_d    = m_we[winner];
          addr_d  = addr_arr[winner];
          be_d    = be_arr[winner];
          wdata_d = wdata_arr[winner];
          rd_en_d = ~m_we[winner];
          wr_en_d = m_we[winner];
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = '0;
        if (dram_ack) begin
          m_ack_d[grant_q] = 1'b1;
          m_rdata_d        = we_q ? '0 : dram_mem_read_data;
          state_d          = DONE;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (dram_ack) begin
          m_ack_d[grant_q] = 1'b1;
          m_rdata_d        = we_q ? '0 : dram_mem_read_data;
          state_d          = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog expired: complete with an error instead of hanging.
          m_ack_d[grant_q] = 1'b1;
          m_err_d[grant_q] = 1'b1;
          m_rdata_d        = '0;
          state_d          = DONE;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end

      DONE: begin
        mask_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // -------------------------------------------------------------------------
  // State register; reset_n clears asynchronously, sync_reset on the edge
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b1;
      mask_q    <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      m_ack_q   <= 2'b00;
      m_err_q   <= 2'b00;
      m_rdata_q <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
    end else if (sync_reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b1;
      mask_q    <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      m_ack_q   <= 2'b00;
      m_err_q   <= 2'b00;
      m_rdata_q <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign m_ack                = m_ack_q;
  assign m_err                = m_err_q;
  assign m_rdata              = m_rdata_q;
  assign dram_mem_addr        = addr_q;
  assign dram_mem_read_en     = rd_en_q;
  assign dram_mem_write_en    = wr_en_q;
  assign dram_mem_byte_enable = be_q;
  assign dram_mem_write_data  = wdata_q;
  assign busy                 = busy_q;

endmodule
